// File: rtl/axil_master_bridge.sv
// rtl/axil_master_bridge.sv - AXI4-Lite master bridging a CPU memory port to a peripheral window
module axil_master_bridge #(
  parameter int unsigned             ADDR_W    = 32,
  parameter int unsigned             DATA_W    = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = 'h0000_0300,
  parameter int unsigned             WIN_BITS  = 8,
  parameter int unsigned             TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cpu_mem_addr,
  input  logic [DATA_W-1:0]     cpu_wr_data,
  input  logic [DATA_W/8-1:0]   cpu_wr_strb,
  input  logic                  cpu_wr_en,
  input  logic                  cpu_rd_en,
  output logic                  axi_op,
  output logic                  axi_busy,
  output logic                  axi_done,
  output logic [DATA_W-1:0]     axi_rd_data,
  output logic [1:0]            axi_resp,
  output logic                  axi_err,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [1:0]            M_AXI_BRESP,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP
);

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WRESP   = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] OFF_MASK  = (ADDR_W'(1) << WIN_BITS) - ADDR_W'(1);
  localparam logic [31:0]       WDOG_LAST = 32'(TIMEOUT) - 32'd1;

  logic [2:0]        state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        resp_q, resp_d;
  logic [31:0]       wdog_q, wdog_d;

  logic              win_hit;
  logic              wdog_hit;
  logic              aw_hs, w_hs;

  assign win_hit  = (cpu_mem_addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS]);
  assign axi_op   = win_hit && (cpu_wr_en || cpu_rd_en);
  assign wdog_hit = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);
  assign aw_hs    = awvalid_q && M_AXI_AWREADY;
  assign w_hs     = wvalid_q && M_AXI_WREADY;

  // Next-state logic: request capture, handshakes, response capture and watchdog abort
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_data_d = rd_data_q;
    resp_d    = resp_q;
    wdog_d    = wdog_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (axi_op) begin
          // A simultaneous read request is dropped in favour of the write.
          if (cpu_wr_en) begin
            awaddr_d  = cpu_mem_addr & OFF_MASK;
            wdata_d   = cpu_wr_data;
            wstrb_d   = cpu_wr_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            araddr_d  = cpu_mem_addr & OFF_MASK;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WRESP;
        end else if (wdog_hit) begin
          state_d = S_DONE;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          state_d = S_DONE;
        end else if (wdog_hit) begin
          state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end else if (wdog_hit) begin
          state_d = S_DONE;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rd_data_d = M_AXI_RDATA;
          resp_d    = M_AXI_RRESP;
          state_d   = S_DONE;
        end else if (wdog_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wdog_d  = wdog_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort: withdraw every request and report a DECERR-coded failure.
    if (wdog_hit && (state_q != S_IDLE) && (state_q != S_DONE) && (state_d == S_DONE)
        && !(state_q == S_WRESP && M_AXI_BVALID) && !(state_q == S_RD_DATA && M_AXI_RVALID)) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      resp_d    = 2'b11;
    end
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_data_q <= '0;
      resp_q    <= 2'b00;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
      resp_q    <= resp_d;
      wdog_q    <= wdog_d;
    end
  end

  assign axi_busy      = (state_q != S_IDLE);
  assign axi_done      = (state_q == S_DONE);
  assign axi_err       = (state_q == S_DONE) && (resp_q != 2'b00);
  assign axi_rd_data   = rd_data_q;
  assign axi_resp      = resp_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = (state_q == S_WRESP);
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb/tb_axil_master_bridge.sv - directed self-checking bench for axil_master_bridge
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_strb;
  logic        cpu_wr_en, cpu_rd_en;
  logic        axi_op, axi_busy, axi_done, axi_err;
  logic [31:0] axi_rd_data;
  logic [1:0]  axi_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  axil_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0000_0300), .WIN_BITS(8), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_addr(cpu_mem_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_strb(cpu_wr_strb),
    .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .axi_op(axi_op), .axi_busy(axi_busy), .axi_done(axi_done),
    .axi_rd_data(axi_rd_data), .axi_resp(axi_resp), .axi_err(axi_err),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    cpu_mem_addr = '0; cpu_wr_data = '0; cpu_wr_strb = '0;
    idle_inputs();
    tick(); tick();
    check("rst_valid_ready", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_status", {axi_busy, axi_done, axi_err, axi_resp}, 5'b0);
    check("rst_payload", {awaddr, araddr}, 64'h0);
    check("rst_data", {wdata, wstrb, axi_rd_data}, 68'h0);
    check("prot", {awprot, arprot}, 6'b0);
    reset = 1'b0;
    tick();

    // Write 0x304, zero-wait slave
    cpu_mem_addr = 32'h304; cpu_wr_data = 32'hDEADBEEF; cpu_wr_strb = 4'b0011; cpu_wr_en = 1'b1;
    awready = 1'b1; wready = 1'b1;
    #1 check("w1_op", axi_op, 1'b1);
    tick();
    check("w1_c1_valids", {awvalid, wvalid, bready}, 3'b110);
    check("w1_awaddr", awaddr, 32'h04);
    check("w1_wdata", {wdata, wstrb}, {32'hDEADBEEF, 4'b0011});
    tick();
    check("w1_c2", {awvalid, wvalid, bready, axi_done}, 4'b0010);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    check("w1_c3_done", {axi_done, axi_err, axi_resp, bready}, 5'b10000);
    bvalid = 1'b0;
    tick();
    idle_inputs();
    check("w1_c4", {axi_done, axi_busy}, 2'b00);
    tick();

    // Write: W handshakes first, AW two cycles later
    cpu_mem_addr = 32'h310; cpu_wr_data = 32'hA5A5A5A5; cpu_wr_strb = 4'hF; cpu_wr_en = 1'b1;
    tick();
    check("w2a_c1", {awvalid, wvalid}, 2'b11);
    wready = 1'b1;
    tick();
    check("w2a_c2", {awvalid, wvalid, bready}, 3'b100);
    wready = 1'b0;
    tick();
    check("w2a_c3", {awvalid, wvalid, bready}, 3'b100);
    awready = 1'b1;
    tick();
    check("w2a_c4", {awvalid, wvalid, bready, axi_done}, 4'b0010);
    awready = 1'b0; bvalid = 1'b1;
    tick();
    check("w2a_done", {axi_done, axi_err}, 2'b10);
    bvalid = 1'b0;
    tick();
    idle_inputs();
    check("w2a_single_done", {axi_done, axi_busy}, 2'b00);
    tick();

    // Write: AW handshakes first, W three cycles later
    cpu_mem_addr = 32'h314; cpu_wr_en = 1'b1;
    tick();
    awready = 1'b1;
    tick();
    check("w2b_c2", {awvalid, wvalid, bready}, 3'b010);
    awready = 1'b0;
    tick();
    check("w2b_c3", {awvalid, wvalid, bready}, 3'b010);
    tick();
    check("w2b_c4", {awvalid, wvalid, bready}, 3'b010);
    wready = 1'b1;
    tick();
    check("w2b_c5", {awvalid, wvalid, bready}, 3'b001);
    wready = 1'b0; bvalid = 1'b1;
    tick();
    check("w2b_done", {axi_done, axi_err}, 2'b10);
    bvalid = 1'b0;
    tick();
    idle_inputs();
    check("w2b_single_done", axi_done, 1'b0);
    tick();

    // Read 0x3FC with four slave wait cycles and SLVERR
    cpu_mem_addr = 32'h3FC; cpu_rd_en = 1'b1;
    tick();
    check("r_c1", {arvalid, rready, awvalid}, 3'b100);
    check("r_araddr", araddr, 32'hFC);
    arready = 1'b1;
    tick();
    check("r_c2", {arvalid, rready}, 2'b01);
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_wait", {rready, axi_done}, 2'b10);
    end
    tick();
    rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
    tick();
    check("r_done", {axi_done, axi_err, axi_resp}, 4'b1110);
    check("r_data", axi_rd_data, 32'h12345678);
    rvalid = 1'b0;
    tick();
    idle_inputs();
    check("r_after", {axi_done, axi_busy, rready}, 3'b000);
    tick();

    // Out-of-window write is ignored
    cpu_mem_addr = 32'h400; cpu_wr_en = 1'b1;
    #1 check("oow_op", axi_op, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("oow_idle", {axi_busy, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
    end
    idle_inputs();
    tick();

    // Watchdog: AWREADY never arrives
    cpu_mem_addr = 32'h308; cpu_wr_en = 1'b1; wready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) wready = 1'b0;
    end
    check("to_c8", {awvalid, axi_done, axi_busy}, 3'b101);
    tick();
    check("to_done", {awvalid, wvalid, bready, axi_done, axi_err, axi_resp}, 7'b0001111);
    tick();
    idle_inputs();
    check("to_after", {axi_done, axi_busy}, 2'b00);
    tick();

    // Write and read together: write wins, read data untouched
    cpu_mem_addr = 32'h320; cpu_wr_data = 32'h0BADF00D; cpu_wr_en = 1'b1; cpu_rd_en = 1'b1;
    awready = 1'b1; wready = 1'b1;
    tick();
    check("both_c1", {awvalid, wvalid, arvalid}, 3'b110);
    tick();
    bvalid = 1'b1;
    tick();
    check("both_done", {axi_done, axi_err, axi_resp}, 4'b1000);
    check("both_rdata_kept", axi_rd_data, 32'h12345678);
    bvalid = 1'b0;
    tick();
    idle_inputs();
    tick();

    // Reset during RD_DATA
    cpu_mem_addr = 32'h330; cpu_rd_en = 1'b1; arready = 1'b1;
    tick();
    tick();
    check("rst_mid_rd", rready, 1'b1);
    arready = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_mid_outs", {axi_busy, axi_done, axi_err, arvalid, rready, axi_resp}, 7'b0);
    check("rst_mid_data", {araddr, axi_rd_data}, 64'h0);
    idle_inputs();
    reset = 1'b0;
    tick();
    check("rst_mid_nodone", {axi_done, axi_busy}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master_bridge.md
# axil_master_bridge

Parametrised AXI4-Lite master bridging the multicycle CPU's memory port to memory-mapped peripherals. Claims any CPU access falling inside a configurable address window, runs one AXI4-Lite read or write with byte strobes, and stalls the CPU until completion. Reports the AXI response code and signals an error on SLVERR/DECERR. A watchdog recovers from a peripheral that never responds.

## Interface
- ADDR_W, 32, CPU and AXI address width
- DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8
- BASE_ADDR, 32'h0000_0300, window base, aligned to 2^WIN_BITS
- WIN_BITS, 8, window size is 2^WIN_BITS bytes
- TIMEOUT, 255, max cycles per transaction before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_mem_addr  in  ADDR_W  byte address
- cpu_wr_data  in  DATA_W  write data
- cpu_wr_strb  in  STRB_W  byte enables for writes
- cpu_wr_en / cpu_rd_en  in  1  request strobes, held until axi_done
- axi_op  out  1  combinational: address in window and (wr_en | rd_en)
- axi_busy  out  1  high in every state except IDLE
- axi_done  out  1  one-cycle completion pulse
- axi_rd_data  out  DATA_W  registered read data
- axi_resp  out  2  response of the last completed transaction
- axi_err  out  1  valid with axi_done: resp != OKAY or timeout
- M_AXI_AW*: AWVALID out 1, AWREADY in 1, AWADDR out ADDR_W, AWPROT out 3
- M_AXI_W*: WVALID out 1, WREADY in 1, WDATA out DATA_W, WSTRB out STRB_W
- M_AXI_B*: BVALID in 1, BREADY out 1, BRESP in 2
- M_AXI_AR*: ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W, ARPROT out 3
- M_AXI_R*: RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in 2

## Operation
- Window hit: cpu_mem_addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS].
- AXI address = {zeros, cpu_mem_addr[WIN_BITS-1:0]}, i.e. the offset within the window.
- AWPROT and ARPROT are always 3'b000.
- FSM states: IDLE, WR, WRESP, RD_ADDR, RD_DATA, DONE.
- IDLE: if axi_op and wr_en, go to WR. Latch AWADDR, WDATA and WSTRB; set AWVALID=WVALID=1.
- IDLE: if axi_op and rd_en only, go to RD_ADDR. Latch ARADDR; set ARVALID=1.
- If wr_en and rd_en are both high, the write wins and the read is dropped.
- WR: AW and W handshake independently, in any order.
  - Each VALID drops on its own handshake edge.
  - Per-channel done flags record completion.
  - Go to WRESP once both flags are set, including when both handshakes occur in the same cycle.
- WRESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_ADDR: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA into axi_rd_data and RRESP into axi_resp, then go to DONE.
- axi_rd_data is unchanged by writes.
- DONE: axi_done=1 for one cycle, then go to IDLE. axi_err = (axi_resp != 2'b00).
- The CPU deasserts its enables in the cycle after axi_done. A request still held in IDLE is treated as new.
- Watchdog:
  - Counter clears in IDLE and increments in every other non-DONE state.
  - On reaching TIMEOUT: all VALID/READY outputs drop, axi_resp=2'b11, axi_err=1, go to DONE.
  - Deliberate deviation for hung-slave recovery; any late slave response is ignored.
- Requests with no window hit are ignored: axi_op=0 and all AXI outputs idle.

## Timing
- Reset values: FSM IDLE; all VALID/READY 0; AWADDR, ARADDR, WDATA, WSTRB, axi_rd_data, axi_resp all 0; axi_done, axi_err, axi_busy 0.
- Reset mid-transaction: reset values on the next edge, no axi_done pulse.
- Request sampled at edge 0: VALIDs high in cycle 1.
- Zero-wait slave: response handshake in cycle 2, axi_done in cycle 3 (3-cycle latency). Each slave wait cycle adds one cycle.
- READY stays low outside WRESP/RD_DATA; at most one transaction outstanding.
- VALID and its payload are stable from assertion until handshake.

## Test plan
- Write addr 0x304, data 0xDEADBEEF, strb 4'b0011, slave always ready -> AWADDR=0x04, WSTRB=0011, axi_done in cycle 3, axi_err=0.
- Write with WREADY 2 cycles before AWREADY, then AWREADY 3 cycles before WREADY -> each VALID drops on its own handshake; BREADY rises only after both; one axi_done each.
- Read 0x3FC, RDATA=0x12345678 with RRESP=2'b10 after 4 wait cycles -> axi_rd_data=0x12345678, axi_resp=10, axi_err=1.
- Write to 0x400 (outside window) -> axi_op=0, no AXI activity, axi_busy stays 0.
- TIMEOUT=8, slave never asserts AWREADY -> after 8 busy cycles VALIDs drop, axi_done with axi_resp=11, axi_err=1.
- wr_en and rd_en both high -> write only; reset asserted during RD_DATA -> all outputs at reset values next cycle, no axi_done.
